// File: rtl/tetris_pkg.sv
// Shared piece encoding and queue FSM state type for the piece path.
package tetris_pkg;

   localparam int PIECE_W = 3;

   localparam logic [PIECE_W-1:0] PIECE_I    = 3'd0;
   localparam logic [PIECE_W-1:0] PIECE_O    = 3'd1;
   localparam logic [PIECE_W-1:0] PIECE_T    = 3'd2;
   localparam logic [PIECE_W-1:0] PIECE_S    = 3'd3;
   localparam logic [PIECE_W-1:0] PIECE_Z    = 3'd4;
   localparam logic [PIECE_W-1:0] PIECE_J    = 3'd5;
   localparam logic [PIECE_W-1:0] PIECE_L    = 3'd6;
   localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // A code is a real piece unless it is the "none" marker.
   function automatic logic piece_valid(input logic [PIECE_W-1:0] p);
      return (p != PIECE_NONE);
   endfunction

endpackage

// File: rtl/piece_fifo.sv
// Shift-register preview FIFO. Slot 0 is always the head; a pop shifts every
// slot down by one, and a push lands in the first free slot after any shift.
// Empty slots read as PIECE_NONE.
module piece_fifo
   import tetris_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [PIECE_W-1:0]           push_piece,
   input  logic                         pop,
   output logic [PIECE_W-1:0]           head,
   output logic [PIECE_W*DEPTH-1:0]     slots,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [$clog2(DEPTH+1)-1:0]   count_next
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [PIECE_W-1:0] slot_r [DEPTH];
   logic [PIECE_W-1:0] slot_n [DEPTH];
   logic [CW-1:0]      count_r;
   logic [CW-1:0]      count_n;
   logic [CW-1:0]      wr_idx_s;
   logic               pop_ok_s;
   logic               push_ok_s;

   // Next slot contents and occupancy from the push/pop pair.
   always_comb begin
      pop_ok_s  = pop && (count_r != {CW{1'b0}});
      push_ok_s = push && ((count_r < DEPTH_C) || pop_ok_s);
      wr_idx_s  = pop_ok_s ? (count_r - CW'(1)) : count_r;
      for (int i = 0; i < DEPTH; i++) begin
         slot_n[i] = slot_r[i];
      end
      if (pop_ok_s) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            slot_n[i] = slot_r[i+1];
         end
         slot_n[DEPTH-1] = PIECE_NONE;
      end else begin
         slot_n[0] = slot_n[0];
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (push_ok_s && (wr_idx_s == CW'(i))) begin
            slot_n[i] = push_piece;
         end else begin
            slot_n[i] = slot_n[i];
         end
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_n = count_r + CW'(1);
         2'b01:   count_n = count_r - CW'(1);
         default: count_n = count_r;
      endcase
   end

   // Slot and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_r[i] <= PIECE_NONE;
         end
         count_r <= {CW{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_r[i] <= slot_n[i];
         end
         count_r <= count_n;
      end
   end

   // Flattened parallel view of the slots, head in the low bits.
   always_comb begin
      slots = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slots[PIECE_W*i +: PIECE_W] = slot_r[i];
      end
   end

   assign head       = slot_r[0];
   assign count      = count_r;
   assign count_next = count_n;

endmodule

// File: rtl/piece_queue.sv
// Piece queue: throttles the generator into a preview FIFO with a one-shot
// repeat filter, owns the hold slot and its per-spawn lock, and answers the
// game FSM's spawn/hold requests with a single-cycle response pulse.
module piece_queue
   import tetris_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int REROLL = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         gen_enable,
   input  logic                         gen_ready,
   input  logic [PIECE_W-1:0]           gen_piece,
   input  logic                         spawn_req,
   input  logic                         hold_req,
   input  logic [PIECE_W-1:0]           hold_in,
   output logic                         resp_valid,
   output logic [PIECE_W-1:0]           resp_piece,
   output logic                         resp_from_hold,
   output logic                         busy,
   output logic [PIECE_W*DEPTH-1:0]     preview,
   output logic [$clog2(DEPTH+1)-1:0]   preview_count,
   output logic [PIECE_W-1:0]           hold_piece,
   output logic                         hold_locked
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t              state_r, state_n;
   logic                gen_enable_r;
   logic [PIECE_W-1:0]  last_r;
   logic                reroll_used_r;
   logic [PIECE_W-1:0]  hold_r, hold_n;
   logic                locked_r, locked_n;
   logic                spawn_mode_r, spawn_mode_n;
   logic                resp_valid_r, resp_valid_n;
   logic [PIECE_W-1:0]  resp_piece_r, resp_piece_n;
   logic                resp_from_hold_r, resp_from_hold_n;
   logic                busy_r;

   logic                cand_s;
   logic                reroll_hit_s;
   logic                push_s;
   logic                pop_s;
   logic [PIECE_W-1:0]  head_s;
   logic [CW-1:0]       count_s;
   logic [CW-1:0]       count_next_s;

   piece_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_s),
      .push_piece (gen_piece),
      .pop        (pop_s),
      .head       (head_s),
      .slots      (preview),
      .count      (count_s),
      .count_next (count_next_s)
   );

   // Candidate acceptance: a repeat of the last accepted piece is thrown away
   // once, after which the next candidate is taken regardless.
   always_comb begin
      cand_s = gen_enable_r && gen_ready && piece_valid(gen_piece) &&
               ((count_s < DEPTH_C) || pop_s);
      reroll_hit_s = cand_s && (REROLL != 0) && !reroll_used_r &&
                     (gen_piece == last_r);
      push_s = cand_s && !reroll_hit_s;
   end

   // Request FSM: decides pops, hold-slot updates and the response contents.
   always_comb begin
      state_n          = state_r;
      pop_s            = 1'b0;
      hold_n           = hold_r;
      locked_n         = locked_r;
      spawn_mode_n     = spawn_mode_r;
      resp_valid_n     = 1'b0;
      resp_piece_n     = PIECE_NONE;
      resp_from_hold_n = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (spawn_req) begin
               spawn_mode_n = 1'b1;
               if (count_s != {CW{1'b0}}) begin
                  pop_s        = 1'b1;
                  resp_valid_n = 1'b1;
                  resp_piece_n = head_s;
                  locked_n     = 1'b0;
                  state_n      = S_RESP;
               end else begin
                  state_n = S_WAIT;
               end
            end else if (hold_req && !locked_r && piece_valid(hold_in)) begin
               hold_n   = hold_in;
               locked_n = 1'b1;
               if (piece_valid(hold_r)) begin
                  resp_valid_n     = 1'b1;
                  resp_piece_n     = hold_r;
                  resp_from_hold_n = 1'b1;
                  state_n          = S_RESP;
               end else begin
                  // Empty hold: the game still needs a new piece, taken from
                  // the queue, but the lock must survive this response.
                  spawn_mode_n = 1'b0;
                  if (count_s != {CW{1'b0}}) begin
                     pop_s        = 1'b1;
                     resp_valid_n = 1'b1;
                     resp_piece_n = head_s;
                     state_n      = S_RESP;
                  end else begin
                     state_n = S_WAIT;
                  end
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_WAIT: begin
            if (count_s != {CW{1'b0}}) begin
               pop_s        = 1'b1;
               resp_valid_n = 1'b1;
               resp_piece_n = head_s;
               locked_n     = spawn_mode_r ? 1'b0 : locked_r;
               state_n      = S_RESP;
            end else begin
               state_n = S_WAIT;
            end
         end
         S_RESP: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State, hold slot, filter history and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= S_IDLE;
         gen_enable_r     <= 1'b0;
         last_r           <= PIECE_NONE;
         reroll_used_r    <= 1'b0;
         hold_r           <= PIECE_NONE;
         locked_r         <= 1'b0;
         spawn_mode_r     <= 1'b0;
         resp_valid_r     <= 1'b0;
         resp_piece_r     <= PIECE_NONE;
         resp_from_hold_r <= 1'b0;
         busy_r           <= 1'b0;
      end else begin
         state_r          <= state_n;
         gen_enable_r     <= (count_next_s < DEPTH_C);
         hold_r           <= hold_n;
         locked_r         <= locked_n;
         spawn_mode_r     <= spawn_mode_n;
         resp_valid_r     <= resp_valid_n;
         resp_piece_r     <= resp_piece_n;
         resp_from_hold_r <= resp_from_hold_n;
         busy_r           <= (state_n != S_IDLE);
         if (push_s) begin
            last_r        <= gen_piece;
            reroll_used_r <= 1'b0;
         end else if (reroll_hit_s) begin
            last_r        <= last_r;
            reroll_used_r <= 1'b1;
         end else begin
            last_r        <= last_r;
            reroll_used_r <= reroll_used_r;
         end
      end
   end

   assign gen_enable     = gen_enable_r;
   assign resp_valid     = resp_valid_r;
   assign resp_piece     = resp_piece_r;
   assign resp_from_hold = resp_from_hold_r;
   assign busy           = busy_r;
   assign preview_count  = count_s;
   assign hold_piece     = hold_r;
   assign hold_locked    = locked_r;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue (DEPTH=4, REROLL=1).
module tb_piece_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        gen_enable;
   logic        gen_ready;
   logic [2:0]  gen_piece;
   logic        spawn_req;
   logic        hold_req;
   logic [2:0]  hold_in;
   logic        resp_valid;
   logic [2:0]  resp_piece;
   logic        resp_from_hold;
   logic        busy;
   logic [11:0] preview;
   logic [2:0]  preview_count;
   logic [2:0]  hold_piece;
   logic        hold_locked;

   int n_cmp = 0;
   int n_bad = 0;

   piece_queue #(.DEPTH(4), .REROLL(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .gen_enable     (gen_enable),
      .gen_ready      (gen_ready),
      .gen_piece      (gen_piece),
      .spawn_req      (spawn_req),
      .hold_req       (hold_req),
      .hold_in        (hold_in),
      .resp_valid     (resp_valid),
      .resp_piece     (resp_piece),
      .resp_from_hold (resp_from_hold),
      .busy           (busy),
      .preview        (preview),
      .preview_count  (preview_count),
      .hold_piece     (hold_piece),
      .hold_locked    (hold_locked)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; gen_ready = 1'b0; gen_piece = 3'd7;
      spawn_req = 1'b0; hold_req = 1'b0; hold_in = 3'd7;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Generator model: offers seq pieces in order (first in bits [2:0]) and
   // advances only when gen_enable was high at the sampling edge.
   task automatic feed(input logic [23:0] seq, input int n, output int taken);
      int  k;
      logic en;
      k = 0;
      for (int cyc = 0; cyc < 20 && k < n; cyc++) begin
         gen_piece = seq[3*k +: 3];
         gen_ready = 1'b1;
         en = gen_enable;
         tick();
         if (en) k++;
      end
      gen_ready = 1'b0;
      gen_piece = 3'd7;
      taken = k;
   endtask

   task automatic test_reset();
      reset = 1'b1; gen_ready = 1'b0; gen_piece = 3'd7;
      spawn_req = 1'b0; hold_req = 1'b0; hold_in = 3'd7;
      tick(); tick();
      n_cmp++; if (preview !== 12'hFFF) begin n_bad++; $display("FAIL reset_preview: got %h expected fff", preview); end
      n_cmp++; if (preview_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", preview_count); end
      n_cmp++; if ({resp_valid, resp_piece, resp_from_hold, busy, gen_enable, hold_piece, hold_locked} !== 10'b0_111_0_0_0_111_0) begin
         n_bad++; $display("FAIL reset_outputs: got rv=%b rp=%0d rfh=%b busy=%b ge=%b hp=%0d hl=%b expected 0,7,0,0,0,7,0",
                           resp_valid, resp_piece, resp_from_hold, busy, gen_enable, hold_piece, hold_locked);
      end
      reset = 1'b0;
      tick();
      n_cmp++; if (gen_enable !== 1'b1) begin n_bad++; $display("FAIL gen_enable_after_reset: got %b expected 1", gen_enable); end
   endtask

   task automatic test_fill();
      int taken;
      do_reset();
      feed(24'({3'd6, 3'd3, 3'd1, 3'd5, 3'd5, 3'd2}), 6, taken);
      n_cmp++; if (preview !== 12'h66A) begin n_bad++; $display("FAIL fill_preview: got %h expected 66a", preview); end
      n_cmp++; if (preview_count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d expected 4", preview_count); end
      n_cmp++; if (gen_enable !== 1'b0) begin n_bad++; $display("FAIL fill_gen_enable: got %b expected 0", gen_enable); end
      n_cmp++; if (taken !== 5) begin n_bad++; $display("FAIL fill_taken: got %0d expected 5", taken); end
   endtask

   task automatic test_reroll_once();
      int taken;
      do_reset();
      feed(24'({3'd2, 3'd1, 3'd1, 3'd1}), 4, taken);
      tick();
      n_cmp++; if (preview !== 12'hE89) begin n_bad++; $display("FAIL reroll_preview: got %h expected e89", preview); end
      n_cmp++; if (preview_count !== 3'd3) begin n_bad++; $display("FAIL reroll_count: got %0d expected 3", preview_count); end
   endtask

   task automatic test_empty_wait();
      logic got;
      do_reset();
      gen_ready = 1'b1; gen_piece = 3'd7;
      for (int i = 0; i < 5; i++) tick();
      gen_ready = 1'b0;
      n_cmp++; if (preview_count !== 3'd0) begin n_bad++; $display("FAIL none_count: got %0d expected 0", preview_count); end
      n_cmp++; if (preview !== 12'hFFF) begin n_bad++; $display("FAIL none_preview: got %h expected fff", preview); end
      spawn_req = 1'b1; tick(); spawn_req = 1'b0;
      n_cmp++; if ({busy, resp_valid} !== 2'b10) begin n_bad++; $display("FAIL wait_busy: got busy=%b rv=%b expected 1,0", busy, resp_valid); end
      tick();
      gen_piece = 3'd4; gen_ready = 1'b1; tick();
      gen_ready = 1'b0; gen_piece = 3'd7;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
         if (resp_valid) got = 1'b1; else tick();
      end
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL wait_resp_timeout: got no resp_valid expected one"); end
      n_cmp++; if ({resp_piece, resp_from_hold} !== 4'b100_0) begin n_bad++; $display("FAIL wait_resp_piece: got %0d/%b expected 4/0", resp_piece, resp_from_hold); end
      tick();
      n_cmp++; if ({resp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL wait_resp_pulse: got rv=%b busy=%b expected 0,0", resp_valid, busy); end
   endtask

   task automatic test_full_spawn();
      int taken;
      do_reset();
      feed(24'({3'd3, 3'd2, 3'd1, 3'd0}), 4, taken);
      n_cmp++; if (taken !== 4) begin n_bad++; $display("FAIL full_taken: got %0d expected 4", taken); end
      gen_piece = 3'd5; gen_ready = 1'b1; spawn_req = 1'b1;
      tick();
      spawn_req = 1'b0;
      n_cmp++; if ({resp_valid, resp_piece, resp_from_hold} !== 5'b1_000_0) begin
         n_bad++; $display("FAIL full_spawn_resp: got rv=%b rp=%0d rfh=%b expected 1,0,0", resp_valid, resp_piece, resp_from_hold);
      end
      tick();
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL full_spawn_pulse: got %b expected 0", resp_valid); end
      tick();
      gen_ready = 1'b0; gen_piece = 3'd7;
      n_cmp++; if (preview !== 12'hAD1) begin n_bad++; $display("FAIL full_spawn_preview: got %h expected ad1", preview); end
      n_cmp++; if (preview_count !== 3'd4) begin n_bad++; $display("FAIL full_spawn_count: got %0d expected 4", preview_count); end
   endtask

   task automatic test_hold();
      int taken;
      int pulses;
      do_reset();
      feed(24'({3'd3, 3'd2, 3'd1, 3'd0}), 4, taken);
      hold_in = 3'd4; hold_req = 1'b1; tick(); hold_req = 1'b0;
      n_cmp++; if ({resp_valid, resp_piece, resp_from_hold, hold_piece, hold_locked} !== 9'b1_000_0_100_1) begin
         n_bad++; $display("FAIL hold_first: got rv=%b rp=%0d rfh=%b hp=%0d hl=%b expected 1,0,0,4,1",
                           resp_valid, resp_piece, resp_from_hold, hold_piece, hold_locked);
      end
      tick();
      hold_in = 3'd2; hold_req = 1'b1; tick(); hold_req = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || busy) pulses++;
         tick();
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL hold_locked_ignored: got %0d active cycles expected 0", pulses); end
      n_cmp++; if (hold_piece !== 3'd4) begin n_bad++; $display("FAIL hold_locked_keep: got %0d expected 4", hold_piece); end
      spawn_req = 1'b1; tick(); spawn_req = 1'b0;
      n_cmp++; if ({resp_valid, resp_piece} !== 4'b1_001) begin n_bad++; $display("FAIL hold_spawn_resp: got rv=%b rp=%0d expected 1,1", resp_valid, resp_piece); end
      tick();
      n_cmp++; if (hold_locked !== 1'b0) begin n_bad++; $display("FAIL hold_unlock: got %b expected 0", hold_locked); end
      hold_in = 3'd6; hold_req = 1'b1; tick(); hold_req = 1'b0;
      n_cmp++; if ({resp_valid, resp_piece, resp_from_hold, hold_piece} !== 8'b1_100_1_110) begin
         n_bad++; $display("FAIL hold_swap: got rv=%b rp=%0d rfh=%b hp=%0d expected 1,4,1,6", resp_valid, resp_piece, resp_from_hold, hold_piece);
      end
      tick();
      spawn_req = 1'b1; tick(); spawn_req = 1'b0;
      n_cmp++; if ({resp_valid, resp_piece} !== 4'b1_010) begin n_bad++; $display("FAIL hold_spawn2: got rv=%b rp=%0d expected 1,2", resp_valid, resp_piece); end
      tick();
      hold_in = 3'd5; hold_req = 1'b1; spawn_req = 1'b1; tick();
      hold_req = 1'b0; spawn_req = 1'b0;
      n_cmp++; if ({resp_valid, resp_piece, resp_from_hold, hold_piece} !== 8'b1_011_0_110) begin
         n_bad++; $display("FAIL both_req: got rv=%b rp=%0d rfh=%b hp=%0d expected 1,3,0,6", resp_valid, resp_piece, resp_from_hold, hold_piece);
      end
      tick();
      n_cmp++; if (hold_locked !== 1'b0) begin n_bad++; $display("FAIL both_req_lock: got %b expected 0", hold_locked); end
   endtask

   task automatic test_reset_in_wait();
      int taken;
      int pulses;
      do_reset();
      hold_in = 3'd3; hold_req = 1'b1; tick(); hold_req = 1'b0;
      n_cmp++; if ({busy, hold_piece, hold_locked} !== 5'b1_011_1) begin
         n_bad++; $display("FAIL wait_hold_setup: got busy=%b hp=%0d hl=%b expected 1,3,1", busy, hold_piece, hold_locked);
      end
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      n_cmp++; if ({resp_valid, resp_piece, resp_from_hold, busy, gen_enable, hold_piece, hold_locked, preview_count} !== 13'b0_111_0_0_0_111_0_000) begin
         n_bad++; $display("FAIL wait_reset_outputs: got rv=%b rp=%0d rfh=%b busy=%b ge=%b hp=%0d hl=%b cnt=%0d expected 0,7,0,0,0,7,0,0",
                           resp_valid, resp_piece, resp_from_hold, busy, gen_enable, hold_piece, hold_locked, preview_count);
      end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (resp_valid || busy) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL wait_reset_drop: got %0d active cycles expected 0", pulses); end
      feed(24'({3'd2, 3'd4, 3'd0, 3'd6}), 4, taken);
      n_cmp++; if (preview !== 12'h506) begin n_bad++; $display("FAIL refill_preview: got %h expected 506", preview); end
      n_cmp++; if (preview_count !== 3'd4) begin n_bad++; $display("FAIL refill_count: got %0d expected 4", preview_count); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_reroll_once();
      test_empty_wait();
      test_full_spawn();
      test_hold();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/piece_queue.md
Name: piece_queue

Overview:
- Sequences the LFSR piece generator and serves the game controller.
- Keeps a preview FIFO of upcoming pieces and enables the generator only while the FIFO has room.
- Applies a one-shot reroll filter against repeated pieces.
- Owns the hold slot, including the once-per-spawn hold lock.
- Sits between piecegenerator and the game-state FSM. The spawn and hold handshakes are the only path by which new active pieces enter play.

Parameters:
DEPTH, 4, number of preview slots (2..8)
REROLL, 1, 1 = discard a candidate equal to the last accepted piece, at most once per accept; 0 = no filter

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
gen_enable  out  1  enables piece generator; high while FIFO can accept
gen_ready  in  1  generator candidate valid
gen_piece  in  3  generator candidate, 0..6 valid, 7 = none
spawn_req  in  1  pulse: request next active piece from queue
hold_req  in  1  pulse: swap current active piece into hold
hold_in  in  3  current active piece, sampled with hold_req
resp_valid  out  1  one-cycle pulse: resp_piece valid
resp_piece  out  3  piece delivered to game FSM
resp_from_hold  out  1  resp_piece came from hold slot
busy  out  1  request accepted, response not yet issued
preview  out  3*DEPTH  FIFO contents; slot 0 = head in bits [2:0]
preview_count  out  $clog2(DEPTH+1)  occupied slots
hold_piece  out  3  hold slot contents, 7 when empty
hold_locked  out  1  hold used since last spawn

Behaviour:
- Reset state, applied on the clk edge with reset=1:
  - FIFO empty, preview all 7s.
  - preview_count 0, hold_piece 7, hold_locked 0.
  - resp_valid 0, resp_piece 7, resp_from_hold 0, busy 0, gen_enable 0.
  - last-accepted register 7, reroll_used 0, FSM in S_IDLE.
- Reset mid-operation drops any pending request; no resp_valid follows.
- gen_enable is registered: next value = (count_next < DEPTH). It is 1 on the first cycle after reset deasserts.
- Push when gen_enable && gen_ready && gen_piece != 7 && filter passes.
  - Filter: if REROLL && !reroll_used && gen_piece == last, discard the candidate and set reroll_used.
  - Any push updates last and clears reroll_used.
- Push at count==DEPTH is allowed only in a cycle where a pop also occurs. Simultaneous push and pop leaves count unchanged and the FIFO shifts correctly.
- FSM states and transitions:
  - S_IDLE:
    - Samples requests. If spawn_req and hold_req are both high, spawn wins and hold is dropped.
    - hold_req while hold_locked is ignored, with no response.
  - spawn_req:
    - If count>0, go to S_RESP with a pop; else go to S_WAIT.
    - Mode = spawn; hold_locked clears when the response issues.
  - hold_req, lock clear, hold occupied:
    - resp_piece = old hold, resp_from_hold=1, hold <= hold_in, hold_locked <= 1.
    - Go to S_RESP; no pop.
  - hold_req, lock clear, hold empty:
    - hold <= hold_in, hold_locked <= 1.
    - Then behave as spawn from the queue, with resp_from_hold=0 and hold_locked staying 1.
  - S_WAIT:
    - busy=1; stay here while count==0.
    - On count>0, pop the head and go to S_RESP. An entry pushed in cycle t is poppable at t+1.
  - S_RESP:
    - resp_valid=1 for exactly one cycle, then S_IDLE. Requests are ignored in this cycle.
- Latency: request in cycle t with a nonempty queue gives resp_valid in cycle t+1.
- busy = (state != S_IDLE).
- Codes 7 from gen_piece and from hold_in are never stored. hold_req with hold_in==7 is ignored.

Decomposition:
- tetris_pkg:
  - PIECE_W=3; piece codes I=0, O=1, T=2, S=3, Z=4, J=5, L=6; PIECE_NONE=7.
  - FSM state typedef for S_IDLE/S_WAIT/S_RESP.
- Sub-module piece_fifo:
  - Shift-register FIFO, DEPTH x PIECE_W.
  - Push/pop ports, count, flattened parallel read.
  - Same clk/reset convention.

Test Plan:
- Reset then fill, DEPTH=4, REROLL=1, gen feeds 2,5,5,1,3,6 with gen_ready=1 → preview 2,5,1,3 (head first), count 4, gen_enable 0 after fill, 6 not taken.
- gen_ready=1 with gen_piece=7 for 5 cycles on an empty queue → count stays 0. A following spawn_req asserts busy; feeding 4 gives resp_valid with resp_piece 4 one cycle after the push.
- Full queue 0,1,2,3 and a spawn_req while gen offers 5 → resp_piece 0, resp_from_hold 0; preview 1,2,3,5; count stays 4.
- Hold sequence:
  - hold_req with hold_in=4 and hold empty, queue 0,1,2,3 → resp_piece 0, resp_from_hold 0, hold_piece 4, hold_locked 1.
  - Second hold_req → no resp_valid.
  - spawn_req → resp_piece 1, hold_locked 0.
  - hold_req with hold_in=6 → resp_piece 4, resp_from_hold 1, hold_piece 6.
- Simultaneous spawn_req and hold_req → spawn only; hold_piece unchanged.
- Reset asserted in S_WAIT → no resp_valid, all outputs at reset values next cycle. A new fill proceeds normally.
